// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressed data memory: access size encodings,
// FSM state type and data path width.
package dmem_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Load lane selection: picks the addressed byte/halfword out of a big-endian
// aligned word and zero- or sign-extends it to the full data width.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_off,
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte offset 0 lives in the most significant lane (big-endian).
  always_comb begin
    w_byte = i_word[31:24];
    case (i_off)
      2'd0:    w_byte = i_word[31:24];
      2'd1:    w_byte = i_word[23:16];
      2'd2:    w_byte = i_word[15:8];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_off[1] ? i_word[15:0] : i_word[31:16];
  end

  // Extension; word accesses pass straight through regardless of i_signed.
  always_comb begin
    o_data = i_word;
    case (i_size)
      SZ_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/byte_data_mem.sv
// Byte-addressed big-endian data memory with a fixed-latency request/response
// handshake. Define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word
// accesses with rsp_err; otherwise misaligned low address bits are dropped.
module byte_data_mem
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  logic [7:0] r_mem [2**ADDR_W];

  dmem_state_e       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;
  logic [DATA_W-1:0] r_ld_word;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic [ADDR_W-1:0] w_acc_addr;
  logic              w_acc_err;
  logic [ADDR_W-3:0] w_word_idx;
  logic [3:0]        w_lane_we;
  logic [DATA_W-1:0] w_lane_data;
  logic [DATA_W-1:0] w_rd_word;
  logic [DATA_W-1:0] w_ld_data;
  logic              w_last_wait;
  logic              w_commit;
  logic              w_unused_addr;

  // Upper address bits wrap around by design.
  assign w_unused_addr = ^req_addr;

  // Request decode: truncate address, align down, flag reserved/misaligned.
  always_comb begin
    w_acc_addr = req_addr[ADDR_W-1:0];
    w_acc_err  = 1'b0;
    case (req_size)
      SZ_BYTE: ;
      SZ_HALF: begin
`ifdef DMEM_MISALIGN_TRAP_EN
        w_acc_err = req_addr[0];
`endif
        w_acc_addr[0] = 1'b0;
      end
      SZ_WORD: begin
`ifdef DMEM_MISALIGN_TRAP_EN
        w_acc_err = |req_addr[1:0];
`endif
        w_acc_addr[1:0] = 2'b00;
      end
      default: w_acc_err = 1'b1;
    endcase
  end

  assign w_word_idx  = r_addr[ADDR_W-1:2];
  assign w_last_wait = (r_state == WAIT) && (r_cnt == '0);
  assign w_commit    = w_last_wait && r_we && !r_err;

  // Store lane enables; bit 3 / data [31:24] map to byte offset 0.
  always_comb begin
    w_lane_we   = 4'b0000;
    w_lane_data = '0;
    case (r_size)
      SZ_BYTE: begin
        w_lane_we[2'd3 - r_addr[1:0]] = 1'b1;
        w_lane_data                   = {4{r_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_lane_we   = r_addr[1] ? 4'b0011 : 4'b1100;
        w_lane_data = {2{r_wdata[15:0]}};
      end
      SZ_WORD: begin
        w_lane_we   = 4'b1111;
        w_lane_data = r_wdata;
      end
      default: ;
    endcase
  end

  // Aligned word read for loads.
  always_comb begin
    w_rd_word = {r_mem[{w_word_idx, 2'd0}], r_mem[{w_word_idx, 2'd1}],
                 r_mem[{w_word_idx, 2'd2}], r_mem[{w_word_idx, 2'd3}]};
  end

  // Storage: no reset; writes only on the final WAIT cycle of a good store.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      if (w_lane_we[3]) r_mem[{w_word_idx, 2'd0}] <= w_lane_data[31:24];
      if (w_lane_we[2]) r_mem[{w_word_idx, 2'd1}] <= w_lane_data[23:16];
      if (w_lane_we[1]) r_mem[{w_word_idx, 2'd2}] <= w_lane_data[15:8];
      if (w_lane_we[0]) r_mem[{w_word_idx, 2'd3}] <= w_lane_data[7:0];
    end
  end

  dmem_lane_align u_lane_align (
    .i_word   (r_ld_word),
    .i_off    (r_addr[1:0]),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_ld_data)
  );

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_size      <= SZ_BYTE;
      r_signed    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      r_ld_word   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rsp_valid <= 1'b0;
          r_rsp_rdata <= '0;
          r_rsp_err   <= 1'b0;
          if (req_valid) begin
            r_we     <= req_we;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= w_acc_addr;
            r_wdata  <= req_wdata;
            r_err    <= w_acc_err;
            r_cnt    <= CNT_W'(LAT - 1);
            r_state  <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_ld_word <= w_rd_word;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= r_err;
          r_rsp_rdata <= (r_err || r_we) ? '0 : w_ld_data;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_byte_data_mem.sv
// Directed bench for byte_data_mem: table of load/store vectors plus
// hand-written misalignment and reset-abort sequences.
module tb_byte_data_mem;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned LAT    = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks;
  int n_fail;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];

  byte_data_mem #(
    .ADDR_W (ADDR_W),
    .LAT    (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction; returns response fields, latency in cycles and handshake flags.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output logic hs_ok, output logic pulse_ok);
    @(negedge clk);
    hs_ok      = req_ready;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat       = -1;
    rdata     = 32'hxxxx_xxxx;
    err       = 1'bx;
    pulse_ok  = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        lat   = i;
        rdata = rsp_rdata;
        err   = rsp_err;
        break;
      end
      if (req_ready) hs_ok = 1'b0;
    end
    if (lat > 0) begin
      @(posedge clk);
      #1;
      pulse_ok = !rsp_valid;
    end
  endtask

  task automatic run_check(input string name, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        hs_ok;
    logic        pulse_ok;
    do_req(we, size, sgn, addr, wdata, rdata, err, lat, hs_ok, pulse_ok);
    check({name, " rdata"}, rdata, exp_rdata);
    check({name, " err"}, {31'd0, err}, {31'd0, exp_err});
    check({name, " latency"}, lat, LAT + 1);
    check({name, " ready"}, {31'd0, hs_ok}, 32'd1);
    check({name, " pulse"}, {31'd0, pulse_ok}, 32'd1);
  endtask

  initial begin
    int  seen;
    logic [31:0] exp_mis;
    logic        exp_mis_err;
    logic [31:0] exp_after;

    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;

    //             name           we    size   sgn   addr          wdata         exp_rdata     err
    vq.push_back('{"st_w_010",    1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0});
    vq.push_back('{"ld_w_010",    1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
    vq.push_back('{"ld_bs_010",   1'b0, 2'b00, 1'b1, 32'h0000_0010, 32'h0,         32'hFFFF_FFDE, 1'b0});
    vq.push_back('{"ld_hu_012",   1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,         32'h0000_BEEF, 1'b0});
    vq.push_back('{"ld_hs_012",   1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,         32'hFFFF_BEEF, 1'b0});
    vq.push_back('{"ld_bu_013",   1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_00EF, 1'b0});
    vq.push_back('{"st_b_011",    1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'hAAAA_AA55, 32'h0000_0000, 1'b0});
    vq.push_back('{"ld_w_010b",   1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDE55_BEEF, 1'b0});
    vq.push_back('{"ld_w_810",    1'b0, 2'b10, 1'b1, 32'h0000_0810, 32'h0,         32'hDE55_BEEF, 1'b0});
    vq.push_back('{"st_rsvd",     1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1});
    vq.push_back('{"ld_w_010c",   1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDE55_BEEF, 1'b0});
    vq.push_back('{"st_h_012",    1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'hFFFF_1234, 32'h0000_0000, 1'b0});
    vq.push_back('{"ld_w_010d",   1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDE55_1234, 1'b0});
    vq.push_back('{"ld_bs_011",   1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0,         32'h0000_0055, 1'b0});
    vq.push_back('{"ld_hs_010",   1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0,         32'hFFFF_DE55, 1'b0});
    vq.push_back('{"ld_rsvd",     1'b0, 2'b11, 1'b1, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1});

    // Reset state, both while held and after release.
    #12;
    check("rst_hold rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_hold rsp_rdata", rsp_rdata, 32'd0);
    check("rst_hold rsp_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rel req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rel rsp_valid", {31'd0, rsp_valid}, 32'd0);

    foreach (vq[i]) begin
      run_check(vq[i].name, vq[i].we, vq[i].size, vq[i].sgn, vq[i].addr, vq[i].wdata,
                vq[i].exp_rdata, vq[i].exp_err);
    end

    // Misaligned accesses: trap build rejects, default build aligns down.
`ifdef DMEM_MISALIGN_TRAP_EN
    exp_mis     = 32'h0000_0000;
    exp_mis_err = 1'b1;
    exp_after   = 32'hDE55_1234;
`else
    exp_mis     = 32'hDE55_1234;
    exp_mis_err = 1'b0;
    exp_after   = 32'hABCD_1234;
`endif
    run_check("ld_w_013", 1'b0, 2'b10, 1'b0, 32'h0000_0013, 32'h0, exp_mis, exp_mis_err);
    run_check("st_h_011", 1'b1, 2'b01, 1'b0, 32'h0000_0011, 32'h0000_ABCD, 32'h0,
              exp_mis_err);
    run_check("ld_w_after_mis", 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, exp_after, 1'b0);

    // Aliased store, then a store aborted by reset during WAIT.
    run_check("st_w_810", 1'b1, 2'b10, 1'b0, 32'h0000_0810, 32'h1234_5678, 32'h0, 1'b0);
    run_check("ld_w_010e", 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1'b0);

    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_size   = 2'b10;
    req_signed = 1'b0;
    req_addr   = 32'h0000_0010;
    req_wdata  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("abort in_wait", {31'd0, req_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    seen  = 0;
    @(posedge clk);
    #1;
    if (rsp_valid) seen++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    check("abort no_rsp", seen, 0);
    check("abort ready", {31'd0, req_ready}, 32'd1);
    run_check("ld_w_after_abort", 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678,
              1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
